// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller around the execute stage.
//   Produces stage enables and flushes for IF/ID, ID/EX and EX/MEM. It handles
//   external memory stalls, taken branches/jumps (PC_sel), multi-cycle EX ops and
//   load-use hazards. A small FSM holds a multi-cycle op in EX for exactly MC_LAT
//   cycles. A saturating counter records how many cycles the PC was frozen.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ext_stall                      MEM not ready; freeze the whole pipe
//   PC_sel                         registered branch/jump taken (EX/MEM)
//   ex_mc_start                    EX instruction is multi-cycle
//   idex_mem_read, idex_rd         EX instruction is a load / its destination
//   ifid_rs1/rs2, ifid_use_rs1/2   ID source registers and their use flags
//   pc_en, ifid_en, idex_en, pipe_en         stage register enables
//   flush_ifid, flush_idex, flush_exmem      NOP inserts
//   mc_busy                        multi-cycle op in progress, not yet completing
//   stall_cnt                      saturating count of cycles with pc_en=0
module hazard_ctrl #(
    parameter int unsigned RA_W   = 5,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_stall,
    input  logic             PC_sel,
    input  logic             ex_mc_start,
    input  logic             idex_mem_read,
    input  logic [RA_W-1:0]  idex_rd,
    input  logic [RA_W-1:0]  ifid_rs1,
    input  logic [RA_W-1:0]  ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             pipe_en,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {StRun, StMcBusy, StMcDone} state_e;

    // Remaining MC_BUSY cycles after the RUN start cycle (MC_DONE is the last one).
    localparam logic [3:0] McInit = 4'(MC_LAT - 2);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;

    assign load_use = idex_mem_read && (idex_rd != '0) &&
                      ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                       (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        pipe_en     = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        mc_busy     = 1'b0;

        if (rst) begin
            {pc_en, ifid_en, idex_en, pipe_en} = 4'b0000;
            {flush_ifid, flush_idex, flush_exmem} = 3'b111;
            state_d = StRun;
            cnt_d   = '0;
        end else if (ext_stall) begin
            // Freeze everything; PC_sel stays pending because EX/MEM is frozen too.
            {pc_en, ifid_en, idex_en, pipe_en} = 4'b0000;
            mc_busy = (state_q == StMcBusy);
        end else if (PC_sel) begin
            // Wrong-path work, including any multi-cycle op in flight, is discarded.
            {flush_ifid, flush_idex, flush_exmem} = 3'b111;
            state_d = StRun;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (ex_mc_start) begin
                        {pc_en, ifid_en, idex_en, pipe_en} = 4'b0000;
                        mc_busy = 1'b1;
                        if (MC_LAT == 2) begin
                            state_d = StMcDone;
                        end else begin
                            cnt_d   = McInit;
                            state_d = StMcBusy;
                        end
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        flush_idex = 1'b1;
                    end
                end
                StMcBusy: begin
                    {pc_en, ifid_en, idex_en, pipe_en} = 4'b0000;
                    mc_busy = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = StMcDone;
                end
                StMcDone: begin
                    // EX/MEM captures the result; a still-high ex_mc_start is stale.
                    state_d = StRun;
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (rst) begin
            stall_cnt_d = '0;
        end else if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        stall_cnt_q <= stall_cnt_d;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned CNT_W = 4;

    // Expected output bundles: {pc,ifid,idex,pipe, fl_ifid,fl_idex,fl_exmem, mc_busy}
    localparam logic [7:0] E_DEF = 8'b1111_0000;
    localparam logic [7:0] E_RST = 8'b0000_1110;
    localparam logic [7:0] E_EXT = 8'b0000_0000;
    localparam logic [7:0] E_EXB = 8'b0000_0001;  // ext_stall while in MC_BUSY
    localparam logic [7:0] E_MCB = 8'b0000_0001;
    localparam logic [7:0] E_FL  = 8'b1111_1110;
    localparam logic [7:0] E_LU  = 8'b0011_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ext_stall = 1'b0, PC_sel = 1'b0, ex_mc_start = 1'b0, idex_mem_read = 1'b0;
    logic [RA_W-1:0] idex_rd = '0, ifid_rs1 = '0, ifid_rs2 = '0;
    logic ifid_use_rs1 = 1'b0, ifid_use_rs2 = 1'b0;
    logic pc_en, ifid_en, idex_en, pipe_en, flush_ifid, flush_idex, flush_exmem, mc_busy;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl #(.RA_W(RA_W), .MC_LAT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ext_stall(ext_stall), .PC_sel(PC_sel),
        .ex_mc_start(ex_mc_start), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
        .ifid_use_rs2(ifid_use_rs2), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .pipe_en(pipe_en), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exmem(flush_exmem), .mc_busy(mc_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       outs;
        logic [CNT_W-1:0] sc;
        logic [7:0]       id;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int vec_id = 0;
    logic [CNT_W-1:0] exp_sc = '0;

    // Monitor: outputs are combinational, so every cycle presents a response.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e = q.pop_front();
            act = {pc_en, ifid_en, idex_en, pipe_en, flush_ifid, flush_idex, flush_exmem,
                   mc_busy};
            checks++;
            if (act !== e.outs || stall_cnt !== e.sc) begin
                errors++;
                $display("FAIL vec%0d: outs=%b stall_cnt=%0d, required outs=%b stall_cnt=%0d",
                         e.id, act, stall_cnt, e.outs, e.sc);
            end
        end
    end

    // Apply one cycle of inputs and queue the response it must produce.
    task automatic drv(input logic r, input logic ext, input logic pcs, input logic mc,
                       input logic mr, input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs1,
                       input logic [RA_W-1:0] rs2, input logic u1, input logic u2,
                       input logic [7:0] eo);
        exp_t e;
        rst = r; ext_stall = ext; PC_sel = pcs; ex_mc_start = mc;
        idex_mem_read = mr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
        ifid_use_rs1 = u1; ifid_use_rs2 = u2;
        e.outs = eo; e.sc = exp_sc; e.id = 8'(vec_id);
        q.push_back(e);
        vec_id++;
        if (r) exp_sc = '0;
        else if (!eo[7] && exp_sc != '1) exp_sc = exp_sc + 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Plain cycle: only rst/ext_stall/PC_sel/ex_mc_start vary.
    task automatic cyc(input logic r, input logic ext, input logic pcs, input logic mc,
                       input logic [7:0] eo);
        drv(r, ext, pcs, mc, 1'b0, '0, '0, '0, 1'b0, 1'b0, eo);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset for two cycles, then RUN with default enables.
        cyc(1, 0, 0, 0, E_RST);
        cyc(1, 0, 0, 0, E_RST);
        cyc(0, 0, 0, 0, E_DEF);
        // Multi-cycle op held in EX: pipe_en 0,0,0,1 and mc_busy 1,1,1,0.
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 0, 0, 1, E_DEF);
        cyc(0, 0, 0, 0, E_DEF);
        // Load x5 in EX, ID reads rs2=x5: one bubble.
        drv(0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 1, 1, E_LU);
        drv(0, 0, 0, 0, 0, 5'd5, 5'd1, 5'd5, 1, 1, E_DEF);
        // Load to x0 never stalls.
        drv(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, E_DEF);
        // Match on rs1 that is not used: no stall; then rs1 used: stall.
        drv(0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2, 0, 1, E_DEF);
        drv(0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2, 1, 0, E_LU);
        // PC_sel in the second MC_BUSY cycle aborts the op.
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 0, 1, 1, E_FL);
        cyc(0, 0, 0, 0, E_DEF);
        // ext_stall for 3 cycles mid MC_BUSY: EX occupancy stretches to 7.
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 1, 0, 1, E_EXB);
        cyc(0, 1, 0, 1, E_EXB);
        cyc(0, 1, 0, 1, E_EXB);
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 0, 0, 1, E_DEF);
        cyc(0, 0, 0, 0, E_DEF);
        // PC_sel under ext_stall waits for ext_stall to drop.
        cyc(0, 1, 1, 0, E_EXT);
        cyc(0, 0, 1, 0, E_FL);
        cyc(0, 0, 0, 0, E_DEF);
        // Drive stall_cnt into saturation.
        repeat (5) cyc(0, 1, 0, 0, E_EXT);
        cyc(0, 0, 0, 0, E_DEF);
        // Reset mid MC_BUSY, then a fresh op runs its full length.
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 0, 0, 1, E_MCB);
        cyc(1, 0, 0, 1, E_RST);
        cyc(0, 0, 0, 0, E_DEF);
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 0, 0, 1, E_MCB);
        cyc(0, 0, 0, 1, E_DEF);
        cyc(0, 0, 0, 0, E_DEF);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
